// File: rtl/fft_pkg.sv
// Shared constants and state encoding for the radix-2 butterfly engine.
package fft_pkg;

  localparam int unsigned N      = 256;  // transform length (complex points)
  localparam int unsigned M      = 8;    // log2(N), number of passes
  localparam int unsigned DW     = 16;   // sample component width, Q1.15
  localparam int unsigned TW     = 16;   // twiddle component width, Q1.14
  localparam int unsigned AW     = 10;   // sample RAM / twiddle ROM index width
  localparam int unsigned QShift = 14;   // twiddle fraction bits

  typedef enum logic [2:0] {
    StIdle,
    StRdTop,
    StRdBot,
    StMul,
    StWrTop,
    StWrBot,
    StDone
  } state_t;

endpackage

// File: rtl/fft_cmul.sv
// Registered complex multiplier: t = b * w, rounded half-up and scaled back to DW+1 bits.
module fft_cmul #(
  parameter int unsigned DW = fft_pkg::DW,
  parameter int unsigned TW = fft_pkg::TW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [2*DW-1:0]      b,
  input  logic [2*TW-1:0]      w,
  output logic signed [DW:0]   t_re,
  output logic signed [DW:0]   t_im
);
  import fft_pkg::*;

  localparam int unsigned PW = DW + TW + 1;
  localparam logic signed [PW-1:0] Rnd = PW'(1 << (QShift - 1));

  logic signed [DW-1:0]    b_re, b_im;
  logic signed [TW-1:0]    w_re, w_im;
  logic signed [DW+TW-1:0] rr, ii, ri, ir;
  logic signed [PW-1:0]    p_re, p_im;

  // Full-precision products and rounded sums; width PW cannot overflow.
  always_comb begin
    b_re = b[2*DW-1:DW];
    b_im = b[DW-1:0];
    w_re = w[2*TW-1:TW];
    w_im = w[TW-1:0];
    rr   = (DW+TW)'(b_re) * (DW+TW)'(w_re);
    ii   = (DW+TW)'(b_im) * (DW+TW)'(w_im);
    ri   = (DW+TW)'(b_re) * (DW+TW)'(w_im);
    ir   = (DW+TW)'(b_im) * (DW+TW)'(w_re);
    p_re = PW'(rr) - PW'(ii) + Rnd;
    p_im = PW'(ri) + PW'(ir) + Rnd;
  end

  // Output register; loads only when the engine is in its multiply cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      t_re <= '0;
      t_im <= '0;
    end else if (en) begin
      t_re <= (DW+1)'(p_re >>> QShift);
      t_im <= (DW+1)'(p_im >>> QShift);
    end
  end

endmodule

// File: rtl/fft_butterfly_engine.sv
// In-place radix-2 DIT butterfly engine: reads two samples and a twiddle from external
// memories, computes (top +/- bot*W) / 2 and writes both results back.
module fft_butterfly_engine #(
  parameter int unsigned N  = fft_pkg::N,
  parameter int unsigned M  = fft_pkg::M,
  parameter int unsigned DW = fft_pkg::DW,
  parameter int unsigned TW = fft_pkg::TW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ptr_valid,
  output logic                   ptr_ready,
  input  logic [fft_pkg::AW-1:0] i_top,
  input  logic [fft_pkg::AW-1:0] i_bot,
  input  logic [fft_pkg::AW-1:0] address,
  input  logic                   ptr_last,
  output logic [fft_pkg::AW-1:0] mem_addr,
  output logic                   mem_we,
  output logic [2*DW-1:0]        mem_wdata,
  input  logic [2*DW-1:0]        mem_rdata,
  output logic [fft_pkg::AW-1:0] tw_addr,
  input  logic [2*TW-1:0]        tw_data,
  output logic                   busy,
  output logic                   done,
  input  logic                   ack
);
  import fft_pkg::*;

  if (N != (1 << M) || M > AW) begin : gen_param_check
    $error("fft_butterfly_engine: N must equal 2**M and fit the index width");
  end

  state_t              state_q, state_d;
  logic [AW-1:0]       i_top_q, i_bot_q, addr_q;
  logic                last_q;
  logic [2*DW-1:0]     top_q;
  logic [2*TW-1:0]     w_q;
  logic signed [DW:0]  t_re, t_im;
  logic signed [DW-1:0] top_re, top_im;
  logic signed [DW+1:0] sum_re, sum_im, dif_re, dif_im;
  logic [2*DW-1:0]     wdata_top, wdata_bot;
  logic                accept;

  assign accept = ptr_valid && ptr_ready;

  fft_cmul #(
    .DW (DW),
    .TW (TW)
  ) u_cmul (
    .clk   (clk),
    .reset (reset),
    .en    (state_q == StMul),
    .b     (mem_rdata),
    .w     (w_q),
    .t_re  (t_re),
    .t_im  (t_im)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Pointer latches and the captured top sample / twiddle.
  always_ff @(posedge clk) begin
    if (reset) begin
      i_top_q <= '0;
      i_bot_q <= '0;
      addr_q  <= '0;
      last_q  <= 1'b0;
      top_q   <= '0;
      w_q     <= '0;
    end else begin
      if (accept) begin
        i_top_q <= i_top;
        i_bot_q <= i_bot;
        addr_q  <= address;
        last_q  <= ptr_last;
      end
      if (state_q == StRdBot) begin
        top_q <= mem_rdata;
        w_q   <= tw_data;
      end
    end
  end

  // Butterfly sums in DW+2 bits, halved with floor, truncated back to DW.
  always_comb begin
    top_re    = top_q[2*DW-1:DW];
    top_im    = top_q[DW-1:0];
    sum_re    = (DW+2)'(top_re) + (DW+2)'(t_re);
    sum_im    = (DW+2)'(top_im) + (DW+2)'(t_im);
    dif_re    = (DW+2)'(top_re) - (DW+2)'(t_re);
    dif_im    = (DW+2)'(top_im) - (DW+2)'(t_im);
    wdata_top = {DW'(sum_re >>> 1), DW'(sum_im >>> 1)};
    wdata_bot = {DW'(dif_re >>> 1), DW'(dif_im >>> 1)};
  end

  // Next-state and output decode; every output is zero outside the states that drive it.
  always_comb begin
    state_d   = state_q;
    ptr_ready = 1'b0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    tw_addr   = '0;
    busy      = 1'b1;
    done      = 1'b0;
    unique case (state_q)
      StIdle: begin
        ptr_ready = 1'b1;
        busy      = 1'b0;
        if (ptr_valid) state_d = StRdTop;
      end
      StRdTop: begin
        mem_addr = i_top_q;
        tw_addr  = addr_q;
        state_d  = StRdBot;
      end
      StRdBot: begin
        mem_addr = i_bot_q;
        state_d  = StMul;
      end
      StMul: begin
        state_d = StWrTop;
      end
      StWrTop: begin
        mem_we    = 1'b1;
        mem_addr  = i_top_q;
        mem_wdata = wdata_top;
        state_d   = StWrBot;
      end
      StWrBot: begin
        mem_we    = 1'b1;
        mem_addr  = i_bot_q;
        mem_wdata = wdata_bot;
        state_d   = last_q ? StDone : StIdle;
      end
      StDone: begin
        done = 1'b1;
        if (ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_fft_butterfly_engine.sv
// Directed and randomized butterflies against an arithmetic reference model, with
// behavioural sample RAM and twiddle ROM.
module tb_fft_butterfly_engine;

  logic        clk = 1'b0;
  logic        reset, ptr_valid, ptr_ready, ptr_last, mem_we, busy, done, ack;
  logic [9:0]  i_top, i_bot, address, mem_addr, tw_addr;
  logic [31:0] mem_wdata, mem_rdata, tw_data;

  logic [31:0] ram [1024];
  logic [31:0] rom [1024];
  logic        pl_we = 1'b0;
  logic [9:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  fft_butterfly_engine dut (
    .clk       (clk),
    .reset     (reset),
    .ptr_valid (ptr_valid),
    .ptr_ready (ptr_ready),
    .i_top     (i_top),
    .i_bot     (i_bot),
    .address   (address),
    .ptr_last  (ptr_last),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .tw_addr   (tw_addr),
    .tw_data   (tw_data),
    .busy      (busy),
    .done      (done),
    .ack       (ack)
  );

  initial forever #5 clk = ~clk;

  // One-cycle-latency RAM/ROM; preload port used only while the engine is idle.
  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    tw_data   <= rom[tw_addr];
    if (mem_we)     ram[mem_addr] = mem_wdata;
    else if (pl_we) ram[pl_addr] = pl_data;
    cyc <= cyc + 1;
  end

  function automatic longint sx(input longint v, input int bits);
    return (v <<< (64 - bits)) >>> (64 - bits);
  endfunction

  // Reference: t = round(bot*W / 2^14) kept to 17 bits, results floor((top +/- t) / 2).
  function automatic logic [63:0] model(input logic [31:0] top, bot, w);
    longint ar, ai, br, bi, wr, wi, tr, ti;
    ar = longint'($signed(top[31:16]));
    ai = longint'($signed(top[15:0]));
    br = longint'($signed(bot[31:16]));
    bi = longint'($signed(bot[15:0]));
    wr = longint'($signed(w[31:16]));
    wi = longint'($signed(w[15:0]));
    tr = sx((br * wr - bi * wi + 8192) >>> 14, 17);
    ti = sx((br * wi + bi * wr + 8192) >>> 14, 17);
    return {16'((ar + tr) >>> 1), 16'((ai + ti) >>> 1),
            16'((ar - tr) >>> 1), 16'((ai - ti) >>> 1)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk(tag, {ptr_ready, mem_we, mem_addr, mem_wdata, tw_addr, busy, done},
        {1'b1, 1'b0, 10'd0, 32'd0, 10'd0, 1'b0, 1'b0});
  endtask

  task automatic poke(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_we = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_we = 1'b0;
  endtask

  task automatic run_bfly(input logic [9:0] it, ib, ad, input logic [31:0] top, bot, w,
                          input logic [63:0] e);
    int n;
    poke(it, top);
    poke(ib, bot);
    rom[ad] = w;
    i_top = it; i_bot = ib; address = ad; ptr_last = 1'b0; ptr_valid = 1'b1;
    n = 0;
    while (!ptr_ready && n < 20) begin @(negedge clk); n++; end
    chk("ready", 64'(ptr_ready), 64'd1);
    @(negedge clk);
    ptr_valid = 1'b0;
    n = 1;
    while (!mem_we && n < 20) begin @(negedge clk); n++; end
    chk("wr_latency", 64'(n), 64'd4);
    chk("wr_top_addr", 64'(mem_addr), 64'(it));
    @(negedge clk);
    chk("wr_bot", 64'({mem_we, mem_addr}), 64'({1'b1, ib}));
    @(negedge clk);
    chk("ram_top", 64'(ram[it]), 64'(e[63:32]));
    chk("ram_bot", 64'(ram[ib]), 64'(e[31:0]));
  endtask

  initial begin
    logic [9:0]  ht [3], hb [3];
    logic [31:0] hv_t [3], hv_b [3], hv_w [3];
    logic [63:0] he [3];
    int          acc [3];
    int          k, n;
    logic [9:0]  it, ib, ad;
    logic [31:0] top, bot, w;

    reset = 1'b1; ptr_valid = 1'b0; ptr_last = 1'b0; ack = 1'b0;
    i_top = '0; i_bot = '0; address = '0;
    repeat (3) @(negedge clk);
    chk_idle("reset_state");
    reset = 1'b0;

    // Directed corner cases.
    run_bfly(10'd1, 10'd2, 10'd0, {16'd1000, 16'd0}, {16'd200, 16'd0}, {16'd16384, 16'd0},
             {16'd600, 16'd0, 16'd400, 16'd0});
    run_bfly(10'd3, 10'd4, 10'd1, 32'd0, {16'd0, 16'd1000}, {16'd0, 16'hC000},
             {16'd500, 16'd0, 16'hFE0C, 16'd0});
    run_bfly(10'd5, 10'd6, 10'd2, {16'd32767, 16'd0}, {16'd32767, 16'd0}, {16'd16384, 16'd0},
             {16'd32767, 16'd0, 16'd0, 16'd0});
    run_bfly(10'd7, 10'd8, 10'd3, {16'hFFFD, 16'd0}, 32'd0, $urandom,
             {16'hFFFE, 16'd0, 16'hFFFE, 16'd0});

    // Randomized butterflies, full-range samples and twiddles.
    for (int r = 0; r < 16; r++) begin
      it  = 10'($urandom_range(0, 1023));
      ib  = it + 10'($urandom_range(1, 1023));
      ad  = 10'($urandom_range(0, 1023));
      top = $urandom; bot = $urandom; w = $urandom;
      run_bfly(it, ib, ad, top, bot, w, model(top, bot, w));
    end

    // Back-to-back triples with ptr_valid held high; last one raises done.
    for (int j = 0; j < 3; j++) begin
      ht[j] = 10'(100 + 2 * j); hb[j] = 10'(101 + 2 * j);
      hv_t[j] = $urandom; hv_b[j] = $urandom; hv_w[j] = $urandom;
      he[j] = model(hv_t[j], hv_b[j], hv_w[j]);
      poke(ht[j], hv_t[j]);
      poke(hb[j], hv_b[j]);
      rom[10'(200 + j)] = hv_w[j];
    end
    k = 0; n = 0;
    i_top = ht[0]; i_bot = hb[0]; address = 10'd200; ptr_last = 1'b0; ptr_valid = 1'b1;
    while (k < 3 && n < 100) begin
      if (ptr_ready) begin
        acc[k] = cyc;
        k++;
        @(negedge clk);
        if (k < 3) begin
          i_top = ht[k]; i_bot = hb[k]; address = 10'(200 + k); ptr_last = (k == 2);
        end else begin
          ptr_valid = 1'b0;
        end
      end else begin
        @(negedge clk);
      end
      n++;
    end
    chk("accepts", 64'(k), 64'd3);
    chk("interval_1", 64'(acc[1] - acc[0]), 64'd6);
    chk("interval_2", 64'(acc[2] - acc[1]), 64'd6);
    n = 0;
    while (!done && n < 20) begin @(negedge clk); n++; end
    chk("done_cycle", 64'(cyc - acc[2]), 64'd6);
    ptr_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("done_hold", 64'({done, ptr_ready, busy, mem_we}), 64'b1010);
    end
    ack = 1'b1; ptr_valid = 1'b0;
    @(negedge clk);
    ack = 1'b0;
    chk("after_ack", 64'({done, ptr_ready, busy}), 64'b010);
    for (int j = 0; j < 3; j++) begin
      chk("hs_ram_top", 64'(ram[ht[j]]), 64'(he[j][63:32]));
      chk("hs_ram_bot", 64'(ram[hb[j]]), 64'(he[j][31:0]));
    end

    // Reset during WR_TOP: top write commits, bottom write never happens.
    it = 10'd300; ib = 10'd301; ad = 10'd300;
    top = $urandom; bot = $urandom; w = $urandom;
    poke(it, top);
    poke(ib, bot);
    rom[ad] = w;
    i_top = it; i_bot = ib; address = ad; ptr_last = 1'b0; ptr_valid = 1'b1;
    @(negedge clk);
    ptr_valid = 1'b0;
    n = 0;
    while (!mem_we && n < 20) begin @(negedge clk); n++; end
    chk("rst_at_wr_top", 64'({mem_we, mem_addr}), 64'({1'b1, it}));
    reset = 1'b1;
    @(negedge clk);
    chk_idle("reset_mid_bfly");
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ram_bot", 64'(ram[ib]), 64'(bot));
    chk("rst_ram_top", 64'(ram[it]), 64'(model(top, bot, w) >> 32));
    chk_idle("idle_after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fft_butterfly_engine.md
FFT_BUTTERFLY_ENGINE -- requirements
Module: fft_butterfly_engine

Interface
REQ-001 Parameter N, default 256: transform length, number of complex points.
REQ-002 Parameter M, default 8: log2(N), number of passes.
REQ-003 Parameter DW, default 16: signed width of each sample component (Q1.15).
REQ-004 Parameter TW, default 16: signed width of each twiddle component (Q1.14).
REQ-005 Clk  in  1  single clock, all logic on posedge.
REQ-006 Reset  in  1  synchronous, active-high reset.
REQ-007 ptr_valid  in  1  pointer triple {i_top, i_bot, address} is valid.
REQ-008 ptr_ready  out  1  engine accepts a pointer triple this cycle.
REQ-009 i_top, i_bot  in  10 each  sample RAM indices of the butterfly's top and bottom legs.
REQ-010 address  in  10  twiddle ROM index.
REQ-011 ptr_last  in  1  marks the final butterfly of the final pass.
REQ-012 mem_addr  out  10  sample RAM address; mem_we out 1 write enable; mem_wdata out 2*DW {re,im}.
REQ-013 mem_rdata  in  2*DW  sample RAM read data {re,im}, valid one cycle after mem_addr is presented.
REQ-014 tw_addr  out  10  twiddle ROM address; tw_data in 2*TW {cos,-sin}, one-cycle read latency.
REQ-015 Busy  out  1  high in every state except IDLE; Done out 1 high only in DONE.

Function
REQ-016 States: IDLE, RD_TOP, RD_BOT, MUL, WR_TOP, WR_BOT, DONE. Exactly one state is active.
REQ-017 ptr_ready is 1 only in IDLE. A triple is accepted when ptr_valid and ptr_ready are both high; i_top, i_bot, address and ptr_last are then latched. IDLE goes to RD_TOP.
REQ-018 RD_TOP: mem_addr = latched i_top, tw_addr = latched address. Goes to RD_BOT.
REQ-019 RD_BOT: mem_addr = latched i_bot; capture mem_rdata as top, tw_data as W. Goes to MUL.
REQ-020 MUL: capture mem_rdata as bot; register t = bot*W. Goes to WR_TOP.
REQ-021 Complex multiply: t_re = br*wr - bi*wi and t_im = br*wi + bi*wr, full precision; add 2^13, arithmetic shift right 14, truncate to DW+1 bits.
REQ-022 WR_TOP: mem_we=1, mem_addr=i_top, mem_wdata = (top + t) >>> 1 per component. Sum is computed in DW+2 bits, shift is floor, result truncated to DW. Goes to WR_BOT.
REQ-023 WR_BOT: mem_we=1, mem_addr=i_bot, mem_wdata = (top - t) >>> 1 with the same width rules. Goes to DONE if the latched ptr_last=1, otherwise to IDLE.
REQ-024 Throughput is one butterfly per 6 cycles. The first write occurs 4 cycles after acceptance.
REQ-025 DONE: Done=1; ptr_ready=0. On Ack=1 (in 1 Ack) go to IDLE; otherwise hold. ptr_valid is ignored in DONE.
REQ-026 mem_we is 0 in every state other than WR_TOP and WR_BOT.
REQ-027 i_top == i_bot is not legal input; behaviour in that case is unspecified.

Reset
REQ-028 Reset forces state IDLE. All outputs take these values: ptr_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, tw_addr=0, Busy=0, Done=0. All latches and pipeline registers clear to 0.
REQ-029 Reset has priority over all other inputs in the same cycle. Reset asserted mid-butterfly aborts the butterfly, and mem_we is 0 from the next cycle. Writes already committed are not undone.

Structure
REQ-030 A shared package fft_pkg holds N, M, DW, TW, the state encoding, and the Q-format shift constant 14.
REQ-031 One sub-module, fft_cmul: a registered complex multiplier implementing REQ-021, instantiated once.
REQ-032 The sample RAM and twiddle ROM are external to this block.

Verification
REQ-033 Unity twiddle: top=(1000,0), bot=(200,0), W=(16384,0) -> RAM[i_top]=(600,0), RAM[i_bot]=(400,0).
REQ-034 -j twiddle: top=(0,0), bot=(0,1000), W=(0,-16384) -> t=(1000,0), RAM[i_top]=(500,0), RAM[i_bot]=(-500,0).
REQ-035 Full scale: top=(32767,0), bot=(32767,0), W=(16384,0) -> RAM[i_top]=(32767,0), RAM[i_bot]=(0,0); no wrap.
REQ-036 Floor rounding: top=(-3,0), bot=(0,0), any W -> RAM[i_top]=(-2,0), RAM[i_bot]=(-2,0).
REQ-037 Handshake: ptr_valid held high for 3 triples -> each triple is accepted exactly 6 cycles apart. With ptr_last on the third triple, Done rises after its WR_BOT and holds until Ack, then the engine returns to IDLE.
REQ-038 Reset asserted in WR_TOP -> no WR_BOT write occurs; next cycle outputs match REQ-028; RAM[i_bot] is unchanged.
